// File: rtl/collision_detect_pkg.sv
// Shared types and default parameters for the collision detector.
package collision_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int HIT_THRESH_DEF   = 4;
  localparam int FLASH_FRAMES_DEF = 16;
  localparam int SCORE_DIV_DEF    = 64;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] val, input logic inc);
    if (inc && (val != 8'hFF)) begin
      return val + 8'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/collision_detect_if.sv
// Video-side inputs and game-status outputs of the collision detector.
interface collision_detect_if;
  logic        frame;
  logic        start;
  logic        active;
  logic        cube;
  logic [7:0]  obstacle;
  logic        run;
  logic        crash;
  logic [7:0]  crash_mask;
  logic        flash;
  logic [15:0] score;

  modport master (
    output frame, start, active, cube, obstacle,
    input  run, crash, crash_mask, flash, score
  );

  modport slave (
    input  frame, start, active, cube, obstacle,
    output run, crash, crash_mask, flash, score
  );
endinterface

// File: rtl/frame_divider.sv
// Counts enabled frame pulses modulo MODULUS; wrap pulses on the last count.
module frame_divider #(
  parameter int MODULUS = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int CW = (MODULUS > 1) ? $clog2(MODULUS) : 1;
  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  logic [CW-1:0] cnt;

  // A clear in the same cycle as an enable suppresses the wrap
  assign wrap = en & ~clr & (cnt == LAST);

  // Modulo counter with synchronous clear
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/collision_detect.sv
// Per-frame cube/obstacle overlap detector with game state, score and flash.
//
// state | meaning
// IDLE  | waiting for start after reset
// PLAY  | obstacles moving, overlaps counted per frame, score running
// HIT   | crash detected, waiting for the next frame pulse
// OVER  | game over, crashed lines flashing, start restarts play
module collision_detect
  import collision_detect_pkg::*;
#(
  parameter int HIT_THRESH   = HIT_THRESH_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF,
  parameter int SCORE_DIV    = SCORE_DIV_DEF
) (
  input logic               clk,
  input logic               reset,
  collision_detect_if.slave bus
);

  state_t      state, state_nxt;
  logic [7:0]  overlap_cnt, overlap_nxt;
  logic [7:0]  mask, mask_nxt;
  logic [7:0]  pix_mask;
  logic [7:0]  crash_mask_q;
  logic [15:0] score_q;
  logic        run_q, crash_q, flash_q;
  logic        pix_hit, pix_overlap;
  logic        crash_detect, restart;
  logic        score_en, score_wrap;
  logic        flash_en, flash_clr, flash_wrap;

  assign pix_hit      = bus.active & bus.cube;
  assign pix_overlap  = pix_hit & (|bus.obstacle);
  assign pix_mask     = pix_hit ? bus.obstacle : 8'h00;
  assign crash_detect = (state == ST_PLAY) && bus.frame && (overlap_cnt >= 8'(HIT_THRESH));
  assign restart      = (state == ST_OVER) && bus.start;

  // Frame pulses in PLAY advance the score, except the one that declares a crash
  assign score_en  = (state == ST_PLAY) && bus.frame && !crash_detect;
  // Flash phase restarts every time OVER is (re)entered
  assign flash_en  = (state == ST_OVER) && bus.frame;
  assign flash_clr = (state != ST_OVER) || restart;

  frame_divider #(.MODULUS(SCORE_DIV)) u_score_div (
    .clk   (clk),
    .reset (reset),
    .en    (score_en),
    .clr   (restart),
    .wrap  (score_wrap)
  );

  frame_divider #(.MODULUS(FLASH_FRAMES)) u_flash_div (
    .clk   (clk),
    .reset (reset),
    .en    (flash_en),
    .clr   (flash_clr),
    .wrap  (flash_wrap)
  );

  // Next state plus per-frame overlap counter and hit-mask update
  always_comb begin
    state_nxt   = state;
    overlap_nxt = overlap_cnt;
    mask_nxt    = mask;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (bus.frame) begin
          // The pixel in the frame-pulse cycle opens the new frame
          if (crash_detect) state_nxt = ST_HIT;
          overlap_nxt = {7'd0, pix_overlap};
          mask_nxt    = pix_mask;
        end else begin
          overlap_nxt = sat_inc8(overlap_cnt, pix_overlap);
          mask_nxt    = mask | pix_mask;
        end
      end
      ST_HIT: begin
        if (bus.frame) state_nxt = ST_OVER;
      end
      ST_OVER: begin
        if (bus.start) begin
          state_nxt   = ST_PLAY;
          overlap_nxt = 8'd0;
          mask_nxt    = 8'd0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      overlap_cnt  <= 8'd0;
      mask         <= 8'd0;
      crash_mask_q <= 8'd0;
      score_q      <= 16'd0;
      run_q        <= 1'b0;
      crash_q      <= 1'b0;
      flash_q      <= 1'b1;
    end else begin
      state       <= state_nxt;
      overlap_cnt <= overlap_nxt;
      mask        <= mask_nxt;
      run_q       <= (state_nxt == ST_PLAY);
      crash_q     <= (state_nxt == ST_HIT) || (state_nxt == ST_OVER);

      if (crash_detect) begin
        crash_mask_q <= mask;
      end else if (restart) begin
        crash_mask_q <= 8'd0;
      end

      if (restart) begin
        score_q <= 16'd0;
      end else if (score_wrap && (score_q != 16'hFFFF)) begin
        score_q <= score_q + 16'd1;
      end

      if (state_nxt != ST_OVER) begin
        flash_q <= 1'b1;
      end else if (flash_wrap) begin
        flash_q <= ~flash_q;
      end
    end
  end

  assign bus.run        = run_q;
  assign bus.crash      = crash_q;
  assign bus.crash_mask = crash_mask_q;
  assign bus.flash      = flash_q;
  assign bus.score      = score_q;

endmodule

// File: tb/tb_collision_detect.sv
// Directed scoreboard bench for collision_detect with default parameters.
module tb_collision_detect;

  typedef struct packed {
    logic        run;
    logic        crash;
    logic [7:0]  mask;
    logic        flash;
    logic [15:0] score;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  exp_t  mon_a;
  string mon_n;

  collision_detect_if bus();

  collision_detect #(
    .HIT_THRESH   (4),
    .FLASH_FRAMES (16),
    .SCORE_DIV    (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the outputs at negedge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = '{run: bus.run, crash: bus.crash, mask: bus.crash_mask,
                flash: bus.flash, score: bus.score};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s: got run=%0b crash=%0b mask=%h flash=%0b score=%0d, expected run=%0b crash=%0b mask=%h flash=%0b score=%0d",
                 mon_n, mon_a.run, mon_a.crash, mon_a.mask, mon_a.flash, mon_a.score,
                 mon_e.run, mon_e.crash, mon_e.mask, mon_e.flash, mon_e.score);
      end
    end
  end

  task automatic expect_out(input string n, input logic r, input logic c,
                            input logic [7:0] m, input logic f, input logic [15:0] s);
    exp_q.push_back('{run: r, crash: c, mask: m, flash: f, score: s});
    name_q.push_back(n);
  endtask

  // One clock with the given inputs; inputs return to zero after the edge
  task automatic cyc(input logic f, input logic st, input logic a,
                     input logic c, input logic [7:0] o);
    bus.frame    = f;
    bus.start    = st;
    bus.active   = a;
    bus.cube     = c;
    bus.obstacle = o;
    @(posedge clk);
    #1;
    bus.frame    = 1'b0;
    bus.start    = 1'b0;
    bus.active   = 1'b0;
    bus.cube     = 1'b0;
    bus.obstacle = 8'h00;
  endtask

  // Frames with a harmless pixel (cube but no obstacle) then the frame pulse
  task automatic clean_frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic overlaps(input int n, input logic [7:0] o);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, o);
  endtask

  task automatic frame_pulse();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bus.frame = 1'b0; bus.start = 1'b0; bus.active = 1'b0;
    bus.cube = 1'b0; bus.obstacle = 8'h00;

    // Reset overrides a start request
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    expect_out("reset_vals", 1'b0, 1'b0, 8'h00, 1'b1, 16'd0);

    cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    expect_out("idle_no_start", 1'b0, 1'b0, 8'h00, 1'b1, 16'd0);

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    expect_out("start_to_play", 1'b1, 1'b0, 8'h00, 1'b1, 16'd0);

    // Threshold minus one: no crash
    overlaps(3, 8'h04);
    frame_pulse();
    expect_out("three_overlaps", 1'b1, 1'b0, 8'h00, 1'b1, 16'd0);

    // Exactly threshold, plus inactive and obstacle-free cube pixels that must not count
    overlaps(4, 8'h04);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    expect_out("no_crash_mid_frame", 1'b1, 1'b0, 8'h00, 1'b1, 16'd0);
    frame_pulse();
    expect_out("crash_at_thresh", 1'b0, 1'b1, 8'h04, 1'b1, 16'd0);

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    expect_out("hit_ignores_start", 1'b0, 1'b1, 8'h04, 1'b1, 16'd0);
    frame_pulse();
    expect_out("over_entry", 1'b0, 1'b1, 8'h04, 1'b1, 16'd0);

    // Flash: 16 frames high, 16 low, then high again
    clean_frames(15);
    expect_out("flash_hi_15", 1'b0, 1'b1, 8'h04, 1'b1, 16'd0);
    clean_frames(1);
    expect_out("flash_lo_16", 1'b0, 1'b1, 8'h04, 1'b0, 16'd0);
    clean_frames(15);
    expect_out("flash_lo_31", 1'b0, 1'b1, 8'h04, 1'b0, 16'd0);
    clean_frames(1);
    expect_out("flash_hi_32", 1'b0, 1'b1, 8'h04, 1'b1, 16'd0);

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    expect_out("restart_1", 1'b1, 1'b0, 8'h00, 1'b1, 16'd0);

    // Score: 64 and 128 clean frames, then a crash frame that must not count
    clean_frames(63);
    expect_out("score_63", 1'b1, 1'b0, 8'h00, 1'b1, 16'd0);
    clean_frames(1);
    expect_out("score_64", 1'b1, 1'b0, 8'h00, 1'b1, 16'd1);
    clean_frames(64);
    expect_out("score_128", 1'b1, 1'b0, 8'h00, 1'b1, 16'd2);
    clean_frames(63);
    overlaps(4, 8'h81);
    frame_pulse();
    expect_out("crash_no_score", 1'b0, 1'b1, 8'h81, 1'b1, 16'd2);
    frame_pulse();
    expect_out("over_keeps_score", 1'b0, 1'b1, 8'h81, 1'b1, 16'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    expect_out("restart_clears", 1'b1, 1'b0, 8'h00, 1'b1, 16'd0);

    // Pixel on the frame pulse belongs to the new frame
    overlaps(3, 8'h08);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h08);
    expect_out("edge_pixel_new_frame", 1'b1, 1'b0, 8'h00, 1'b1, 16'd0);
    overlaps(3, 8'h08);
    frame_pulse();
    expect_out("crash_following", 1'b0, 1'b1, 8'h08, 1'b1, 16'd0);

    // Reset in OVER while flash is low
    frame_pulse();
    clean_frames(16);
    expect_out("over_flash_lo", 1'b0, 1'b1, 8'h08, 1'b0, 16'd0);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    reset = 1'b0;
    expect_out("reset_mid_flash", 1'b0, 1'b0, 8'h00, 1'b1, 16'd0);

    // Reset mid-frame in PLAY must also clear the overlap counter
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    expect_out("start_again", 1'b1, 1'b0, 8'h00, 1'b1, 16'd0);
    overlaps(2, 8'h01);
    reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h01);
    reset = 1'b0;
    expect_out("reset_mid_frame", 1'b0, 1'b0, 8'h00, 1'b1, 16'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    expect_out("start_after_reset", 1'b1, 1'b0, 8'h00, 1'b1, 16'd0);
    overlaps(3, 8'h01);
    frame_pulse();
    expect_out("count_cleared", 1'b1, 1'b0, 8'h00, 1'b1, 16'd0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
